// File: rtl/regfile_pkg.sv
// Shared constants and address-width helper for the integer register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Address width for a power-of-two register count; at least one bit.
    function automatic int unsigned aw_f(input int unsigned nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port forwarding: picks same-cycle write data over the stored value.
module regfile_bypass_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NWR  = 1
) (
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     reg_data_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0]     data_c_o,
    output logic                hit_c_o
);

    // Ascending scan so the highest-index matching port wins.
    always_comb begin
        data_c_o = reg_data_i;
        hit_c_o  = 1'b0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                data_c_o = wr_data_i[j*XLEN +: XLEN];
                hit_c_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard for
// decode hazard detection; writeback clears busy, issue sets it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    parameter int unsigned AW       = aw_f(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                busy_any
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Writes in port order (highest port wins); issue set applied last so it
    // overrides a retiring write to the same register.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                if (!(ZERO_REG && (wr_addr[j*AW +: AW] == '0))) begin
                    mem_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                end
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && !(ZERO_REG && (iss_addr == '0))) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] fwd_data;
        logic            hit;
        logic            is_zero;

        assign ra      = rd_addr[i*AW +: AW];
        assign is_zero = ZERO_REG && (ra == '0);

        regfile_bypass_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_bypass_mux (
            .rd_addr_i  (ra),
            .reg_data_i (mem_q[ra]),
            .wr_en_i    (wr_en),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .data_c_o   (fwd_data),
            .hit_c_o    (hit)
        );

        // Hardwired zero takes priority over forwarding.
        assign rd_data[i*XLEN +: XLEN] = is_zero ? '0 : (BYPASS ? fwd_data : mem_q[ra]);
        assign rd_busy[i] = !is_zero && busy_q[ra] && !(BYPASS && hit);
    end

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: bypass and non-bypass instances share stimulus; a
// reference model pushes expected read results that are popped mid-cycle.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra [2];
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        iss;
    logic [4:0]  ia;

    logic [9:0]  rd_addr_v;
    logic [9:0]  wr_addr_v;
    logic [63:0] wr_data_v;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        busy_any_b, busy_any_n;

    assign rd_addr_v = {ra[1], ra[0]};
    assign wr_addr_v = {wa[1], wa[0]};
    assign wr_data_v = {wd[1], wd[0]};

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_v), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(we), .wr_addr(wr_addr_v), .wr_data(wr_data_v),
        .iss_valid(iss), .iss_addr(ia), .busy_any(busy_any_b)
    );

    regfile_scoreboard #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_v), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(we), .wr_addr(wr_addr_v), .wr_data(wr_data_v),
        .iss_valid(iss), .iss_addr(ia), .busy_any(busy_any_n)
    );

    typedef struct {
        logic [31:0] d0, d1, nd0, nd1;
        logic        b0, b1, nb0, nb1, bany;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void exp_port(input logic [4:0] a, input bit byp,
                                     output logic [31:0] d, output logic b);
        d = m_mem[a];
        b = m_busy[a];
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] == a) begin
                    d = wd[j];
                    b = 1'b0;
                end
            end
        end
        if (a == 5'd0) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    function automatic void model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            m_busy = '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (we[j]) begin
                    if (wa[j] != 5'd0) m_mem[wa[j]] = wd[j];
                    m_busy[wa[j]] = 1'b0;
                end
            end
            if (iss && ia != 5'd0) m_busy[ia] = 1'b1;
        end
    endfunction

    // Inputs are already driven; predict, compare mid-cycle, then clock the model.
    task automatic run_cycle();
        exp_t e;
        exp_port(ra[0], 1'b1, e.d0, e.b0);
        exp_port(ra[1], 1'b1, e.d1, e.b1);
        exp_port(ra[0], 1'b0, e.nd0, e.nb0);
        exp_port(ra[1], 1'b0, e.nd1, e.nb1);
        e.bany = |m_busy;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq("byp_rd_data0", rd_data_b[31:0],  e.d0);
        check_eq("byp_rd_data1", rd_data_b[63:32], e.d1);
        check_eq("byp_rd_busy0", 32'(rd_busy_b[0]), 32'(e.b0));
        check_eq("byp_rd_busy1", 32'(rd_busy_b[1]), 32'(e.b1));
        check_eq("byp_busy_any", 32'(busy_any_b),   32'(e.bany));
        check_eq("nb_rd_data0",  rd_data_n[31:0],  e.nd0);
        check_eq("nb_rd_data1",  rd_data_n[63:32], e.nd1);
        check_eq("nb_rd_busy0",  32'(rd_busy_n[0]), 32'(e.nb0));
        check_eq("nb_rd_busy1",  32'(rd_busy_n[1]), 32'(e.nb1));
        check_eq("nb_busy_any",  32'(busy_any_n),   32'(e.bany));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = '0; iss = 1'b0; ia = '0;
        wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1; ra[0] = '0; ra[1] = '0;
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;

        // Reset contents: every register reads zero and idle.
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a); ra[1] = 5'(31 - a);
            run_cycle();
        end

        // Write/read and hardwired zero.
        we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; run_cycle();
        idle(); ra[0] = 5'd5; ra[1] = 5'd5; run_cycle();
        we = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234; ra[0] = 5'd0; run_cycle();
        idle(); run_cycle();

        // Same-cycle forwarding versus registered-only view.
        we = 2'b01; wa[0] = 5'd7; wd[0] = 32'hA5A5A5A5; ra[0] = 5'd7; ra[1] = 5'd5; run_cycle();
        idle(); run_cycle();

        // Scoreboard lifecycle on x3.
        iss = 1'b1; ia = 5'd3; ra[0] = 5'd3; run_cycle();
        idle(); run_cycle();
        we = 2'b01; wa[0] = 5'd3; wd[0] = 32'h33; run_cycle();
        idle(); run_cycle();

        // Issue and retire to x9 together; issue to x0.
        iss = 1'b1; ia = 5'd9; ra[0] = 5'd9; run_cycle();
        iss = 1'b1; ia = 5'd9; we = 2'b10; wa[1] = 5'd9; wd[1] = 32'h99; run_cycle();
        idle(); run_cycle();
        we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h999; run_cycle();
        idle(); iss = 1'b1; ia = 5'd0; ra[0] = 5'd0; run_cycle();
        idle(); run_cycle();

        // Two ports to one address, then reset while busy.
        we = 2'b11; wa[0] = 5'd4; wa[1] = 5'd4; wd[0] = 32'h11; wd[1] = 32'h22;
        ra[0] = 5'd4; ra[1] = 5'd4; run_cycle();
        idle(); iss = 1'b1; ia = 5'd4; run_cycle();
        idle(); run_cycle();
        rst = 1'b1; iss = 1'b1; ia = 5'd6; we = 2'b01; wa[0] = 5'd6; wd[0] = 32'h66;
        ra[1] = 5'd6; run_cycle();
        idle(); run_cycle();

        // Random traffic over a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 60) == 0);
            we    = 2'($urandom_range(0, 3));
            wa[0] = 5'($urandom_range(0, 7));
            wa[1] = 5'($urandom_range(0, 7));
            wd[0] = $urandom;
            wd[1] = $urandom;
            iss   = 1'($urandom_range(0, 1));
            ia    = 5'($urandom_range(0, 7));
            ra[0] = 5'($urandom_range(0, 7));
            ra[1] = 5'($urandom_range(0, 7));
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
